// File: rtl/control_unit.sv
// Microprogrammed control unit: decodes micro-address into registered {next_addr, ctrl}.
// Latency: one cycle from addr/Z_flag/MBRU to control_signal/finish.
// Backpressure: enable=0 holds outputs; synchronous rst clears them and overrides enable.
module control_unit #(
  parameter UCODE_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        Z_flag,
  input  logic [5:0]  addr,
  input  logic [5:0]  MBRU,
  output logic [37:0] control_signal,
  output logic        finish
);

  localparam logic [5:0] A_FETCH1 = 6'd0;
  localparam logic [5:0] A_FETCH2 = 6'd1;
  localparam logic [5:0] A_JUMPNZ = 6'd48;
  localparam logic [5:0] A_JUMPZ  = 6'd52;
  localparam logic [5:0] A_END    = 6'd63;

  localparam logic [31:0] C_FETCH1 = 32'h0000_0007;
  localparam logic [31:0] C_FETCH2 = 32'h0000_0018;
  localparam logic [31:0] C_PCLOAD = 32'h0000_0040;
  localparam logic [31:0] C_PCINC  = 32'h0000_0004;

  logic [37:0] control_signal_q, control_signal_d;
  logic        finish_q, finish_d;
  logic [5:0]  next_addr;
  logic [31:0] ctrl;
  logic        branch_taken;

  always_comb begin
    next_addr    = addr + 6'd1;
    ctrl         = 32'h0;
    branch_taken = 1'b0;
    case (addr)
      A_FETCH1: begin
        next_addr = 6'd1;
        ctrl      = C_FETCH1;
      end
      A_FETCH2: begin
        next_addr = MBRU;
        ctrl      = C_FETCH2;
      end
      A_JUMPNZ, A_JUMPZ: begin
        // JUMPNZ takes the branch on Z=0, JUMPZ on Z=1.
        branch_taken = (addr == A_JUMPZ) ? Z_flag : ~Z_flag;
        next_addr    = branch_taken ? MBRU : 6'd0;
        ctrl         = branch_taken ? C_PCLOAD : C_PCINC;
      end
      A_END: begin
        next_addr = A_END;
        ctrl      = 32'h0;
      end
      default: ;
    endcase
  end

  always_comb begin
    control_signal_d = control_signal_q;
    finish_d         = finish_q;
    if (enable) begin
      control_signal_d = {next_addr, ctrl};
      finish_d         = (addr == A_END);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      control_signal_q <= '0;
      finish_q         <= 1'b0;
    end else begin
      control_signal_q <= control_signal_d;
      finish_q         <= finish_d;
    end
  end

  assign control_signal = control_signal_q;
  assign finish         = finish_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed vector table plus randomized
// cycles checked against a rule-level reference model.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst, enable, Z_flag;
  logic [5:0]  addr, MBRU;
  logic [37:0] control_signal;
  logic        finish;

  int n_checks = 0;
  int n_fails  = 0;

  control_unit dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .Z_flag         (Z_flag),
    .addr           (addr),
    .MBRU           (MBRU),
    .control_signal (control_signal),
    .finish         (finish)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        en;
    logic        z;
    logic [5:0]  addr;
    logic [5:0]  mbru;
    logic [37:0] exp_cs;
    logic        exp_fin;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic e, input logic z, input logic [5:0] a,
                     input logic [5:0] m, input logic [5:0] nx, input logic [31:0] c,
                     input logic f, input string nm);
    vec_t v;
    v.rst = r; v.en = e; v.z = z; v.addr = a; v.mbru = m;
    v.exp_cs = {nx, c}; v.exp_fin = f; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [37:0] exp_cs, input logic exp_fin);
    n_checks++;
    if (control_signal !== exp_cs || finish !== exp_fin) begin
      n_fails++;
      $display("FAIL %s: got cs=%h fin=%b, expected cs=%h fin=%b",
               nm, control_signal, finish, exp_cs, exp_fin);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic z,
                      input logic [5:0] a, input logic [5:0] m);
    @(negedge clk);
    rst = r; enable = e; Z_flag = z; addr = a; MBRU = m;
    @(posedge clk);
    #1;
  endtask

  // Reference: rules of the micro-address map, no ucode image loaded.
  function automatic logic [37:0] ref_word(input logic [5:0] a, input logic z,
                                           input logic [5:0] m);
    bit taken;
    if (a == 0)  return {6'd1, 32'h07};
    if (a == 1)  return {m, 32'h18};
    if (a == 63) return {6'd63, 32'h0};
    if (a == 48 || a == 52) begin
      taken = (a == 48) ? !z : z;
      return taken ? {m, 32'h40} : {6'd0, 32'h04};
    end
    return {a + 6'd1, 32'h0};
  endfunction

  initial begin
    logic [37:0] m_cs;
    logic        m_fin;
    logic [5:0]  specials[6];

    rst = 1'b1; enable = 1'b1; Z_flag = 1'b0; addr = 6'd0; MBRU = 6'd0;

    //   rst en z  addr   mbru   next   ctrl    fin
    add(1, 1, 0, 6'd0,  6'd0,  6'd0,  32'h00, 0, "reset_1");
    add(1, 1, 0, 6'd0,  6'd0,  6'd0,  32'h00, 0, "reset_2");
    add(0, 1, 0, 6'd0,  6'd0,  6'd1,  32'h07, 0, "fetch1");
    add(0, 1, 0, 6'd1,  6'd4,  6'd4,  32'h18, 0, "fetch2_dispatch");
    add(0, 0, 1, 6'd0,  6'd9,  6'd4,  32'h18, 0, "hold_1");
    add(0, 0, 0, 6'd48, 6'd9,  6'd4,  32'h18, 0, "hold_2");
    add(0, 0, 0, 6'd63, 6'd9,  6'd4,  32'h18, 0, "hold_3");
    add(0, 1, 0, 6'd48, 6'd47, 6'd47, 32'h40, 0, "jumpnz_taken");
    add(0, 1, 1, 6'd48, 6'd47, 6'd0,  32'h04, 0, "jumpnz_not_taken");
    add(0, 1, 0, 6'd52, 6'd47, 6'd0,  32'h04, 0, "jumpz_not_taken");
    add(0, 1, 1, 6'd52, 6'd47, 6'd47, 32'h40, 0, "jumpz_taken");
    add(0, 1, 1, 6'd5,  6'd9,  6'd6,  32'h00, 0, "seq_ignores_z_mbru");
    add(0, 1, 0, 6'd1,  6'd63, 6'd63, 32'h18, 0, "dispatch_to_end");
    add(0, 1, 0, 6'd62, 6'd0,  6'd63, 32'h00, 0, "addr62");
    add(0, 1, 0, 6'd63, 6'd0,  6'd63, 32'h00, 1, "end_finish");
    add(0, 1, 0, 6'd0,  6'd0,  6'd1,  32'h07, 0, "finish_clears");
    add(0, 1, 0, 6'd63, 6'd5,  6'd63, 32'h00, 1, "end_again");
    add(0, 0, 0, 6'd0,  6'd5,  6'd63, 32'h00, 1, "finish_held_disabled");
    add(1, 1, 0, 6'd63, 6'd5,  6'd0,  32'h00, 0, "reset_during_finish");

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].z, vecs[i].addr, vecs[i].mbru);
      check(vecs[i].name, vecs[i].exp_cs, vecs[i].exp_fin);
    end

    // Reset with enable low still clears: reach finish first.
    step(0, 1, 0, 6'd63, 6'd0);
    check("pre_reset_fin", {6'd63, 32'h0}, 1'b1);
    step(1, 0, 0, 6'd63, 6'd0);
    check("reset_overrides_hold", 38'h0, 1'b0);

    specials = '{6'd0, 6'd1, 6'd48, 6'd52, 6'd62, 6'd63};
    m_cs = '0; m_fin = 1'b0;
    for (int i = 0; i < 400; i++) begin
      logic r, e, z;
      logic [5:0] a, m;
      r = ($urandom_range(0, 19) == 0);
      e = ($urandom_range(0, 4) != 0);
      z = 1'($urandom);
      a = ($urandom_range(0, 1) == 0) ? specials[$urandom_range(0, 5)] : 6'($urandom);
      m = 6'($urandom);
      step(r, e, z, a, m);
      if (r) begin
        m_cs = '0; m_fin = 1'b0;
      end else if (e) begin
        m_cs = ref_word(a, z, m); m_fin = (a == 6'd63);
      end
      check($sformatf("rand_%0d", i), m_cs, m_fin);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
